// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared types and defaults for the ROM download sequencer.
//   state_e  : sequencer FSM states (IDLE, LOAD, HOLD, RUN)
//   region_e : decoded download region (NONE, PROG, GFX, PROM)
//   DEF_*    : default region map and post-download hold length
//   TOTAL_BYTES : size of a complete image with the default map
//   sat_inc16   : 16-bit saturating increment
package rom_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_PROG = 2'd1,
    REG_GFX  = 2'd2,
    REG_PROM = 2'd3
  } region_e;

  localparam int unsigned DEF_PROG_SIZE   = 16384;
  localparam logic [15:0] DEF_GFX_BASE    = 16'h4000;
  localparam int unsigned DEF_GFX_SIZE    = 4096;
  localparam logic [15:0] DEF_PROM_BASE   = 16'h5000;
  localparam int unsigned DEF_PROM_SIZE   = 32;
  localparam int unsigned DEF_HOLD_CYCLES = 16;

  localparam int unsigned TOTAL_BYTES = DEF_PROG_SIZE + DEF_GFX_SIZE + DEF_PROM_SIZE;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: combinational map of a linear download address onto
// the program / graphics / colour-PROM regions.
//   addr_i   : 25-bit linear byte address
//   region_o : region hit, REG_NONE for out-of-range or gap addresses
//   offset_o : address minus the base of the hit region (0 when no hit)
module rom_region_decode
  import rom_dl_pkg::*;
#(
  parameter int unsigned PROG_SIZE = DEF_PROG_SIZE,
  parameter logic [15:0] GFX_BASE  = DEF_GFX_BASE,
  parameter int unsigned GFX_SIZE  = DEF_GFX_SIZE,
  parameter logic [15:0] PROM_BASE = DEF_PROM_BASE,
  parameter int unsigned PROM_SIZE = DEF_PROM_SIZE
) (
  input  logic [24:0] addr_i,
  output region_e     region_o,
  output logic [15:0] offset_o
);

  // Compare in 32 bits so region ends that reach 0x10000 do not wrap.
  localparam logic [31:0] PROG_HI = PROG_SIZE;
  localparam logic [31:0] GFX_LO  = {16'd0, GFX_BASE};
  localparam logic [31:0] GFX_HI  = GFX_LO + GFX_SIZE;
  localparam logic [31:0] PROM_LO = {16'd0, PROM_BASE};
  localparam logic [31:0] PROM_HI = PROM_LO + PROM_SIZE;

  logic [31:0] a;

  always_comb begin
    a        = {7'd0, addr_i};
    region_o = REG_NONE;
    offset_o = '0;
    // Anything above 64K is never part of the image.
    if (addr_i[24:16] == 9'd0) begin
      if (a < PROG_HI) begin
        region_o = REG_PROG;
        offset_o = a[15:0];
      end else if (a >= GFX_LO && a < GFX_HI) begin
        region_o = REG_GFX;
        offset_o = 16'(a - GFX_LO);
      end else if (a >= PROM_LO && a < PROM_HI) begin
        region_o = REG_PROM;
        offset_o = 16'(a - PROM_LO);
      end
    end
  end

endmodule

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: sequences the HPS ioctl ROM download into the core and
// gates the core's run state.
//   clk_sys, reset            : clock, synchronous active-high reset
//   ioctl_download/wr/addr/dout : hps_io download stream
//   prog_we/gfx_we/prom_we    : one-cycle region write enables
//   rom_addr/rom_data         : registered region offset and data for the WE
//   core_reset, ready         : core held in reset until a good image + hold
//   dl_error                  : sticky bad-address flag for the last download
//   byte_count                : saturating count of in-range bytes accepted
//   dbg_state                 : current FSM state (state_e encoding)
//
// Handshake: the ioctl side has no backpressure. A byte is taken on every
// cycle where ioctl_wr and ioctl_download are both 1; an in-range byte
// produces exactly one region WE on the following cycle, with rom_addr and
// rom_data valid alongside it.
module rom_dl_sequencer
  import rom_dl_pkg::*;
#(
  parameter int unsigned PROG_SIZE   = DEF_PROG_SIZE,
  parameter logic [15:0] GFX_BASE    = DEF_GFX_BASE,
  parameter int unsigned GFX_SIZE    = DEF_GFX_SIZE,
  parameter logic [15:0] PROM_BASE   = DEF_PROM_BASE,
  parameter int unsigned PROM_SIZE   = DEF_PROM_SIZE,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        prog_we,
  output logic        gfx_we,
  output logic        prom_we,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        core_reset,
  output logic        ready,
  output logic        dl_error,
  output logic [15:0] byte_count,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] IMAGE_BYTES = 16'(PROG_SIZE + GFX_SIZE + PROM_SIZE);
  localparam int unsigned HW          = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  state_e        state_q;
  logic          dl_q;
  logic [HW-1:0] hold_q;
  logic          prog_we_q, gfx_we_q, prom_we_q;
  logic [15:0]   rom_addr_q;
  logic [7:0]    rom_data_q;
  logic          core_reset_q, ready_q;
  logic          dl_error_q, dl_error_d;
  logic [15:0]   byte_count_q, byte_count_d;

  region_e       region;
  logic [15:0]   offset;
  logic          dl_rise, wr_acc, wr_good, wr_bad;

  rom_region_decode #(
    .PROG_SIZE (PROG_SIZE),
    .GFX_BASE  (GFX_BASE),
    .GFX_SIZE  (GFX_SIZE),
    .PROM_BASE (PROM_BASE),
    .PROM_SIZE (PROM_SIZE)
  ) u_decode (
    .addr_i   (ioctl_addr),
    .region_o (region),
    .offset_o (offset)
  );

  assign dl_rise = ioctl_download & ~dl_q;
  // Writes are taken whenever the download level is high, independent of
  // state, so the rising-edge cycle and post-reset strobes still land.
  assign wr_acc  = ioctl_wr & ioctl_download;
  assign wr_good = wr_acc & (region != REG_NONE);
  assign wr_bad  = wr_acc & (region == REG_NONE);

  // The rising edge clears count/error, but a byte in that same cycle must
  // still be counted, so clear and accumulate are merged here.
  always_comb begin
    byte_count_d = dl_rise ? 16'd0 : byte_count_q;
    dl_error_d   = dl_rise ? 1'b0 : dl_error_q;
    if (wr_good) byte_count_d = sat_inc16(byte_count_d);
    if (wr_bad)  dl_error_d   = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      // Track the live level so a download already in progress is not
      // seen as a new rising edge once reset is released.
      dl_q         <= ioctl_download;
      hold_q       <= '0;
      prog_we_q    <= 1'b0;
      gfx_we_q     <= 1'b0;
      prom_we_q    <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      dl_error_q   <= 1'b0;
      byte_count_q <= '0;
    end else begin
      dl_q         <= ioctl_download;
      byte_count_q <= byte_count_d;
      dl_error_q   <= dl_error_d;
      prog_we_q    <= wr_good && (region == REG_PROG);
      gfx_we_q     <= wr_good && (region == REG_GFX);
      prom_we_q    <= wr_good && (region == REG_PROM);
      if (wr_good) begin
        rom_addr_q <= offset;
        rom_data_q <= ioctl_dout;
      end

      if (dl_rise) begin
        state_q      <= ST_LOAD;
        hold_q       <= '0;
        core_reset_q <= 1'b1;
        ready_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            // No write is accepted while the level is low, so byte_count_q
            // is already final here.
            if (!ioctl_download) begin
              if (byte_count_q == IMAGE_BYTES && !dl_error_q) begin
                state_q <= ST_HOLD;
                hold_q  <= HOLD_LOAD;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_HOLD: begin
            if (hold_q == '0) begin
              state_q      <= ST_RUN;
              core_reset_q <= 1'b0;
              ready_q      <= 1'b1;
            end else begin
              hold_q <= hold_q - 1'b1;
            end
          end
          default: ;  // IDLE and RUN wait for the next rising edge
        endcase
      end
    end
  end

  assign prog_we    = prog_we_q;
  assign gfx_we     = gfx_we_q;
  assign prom_we    = prom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign core_reset = core_reset_q;
  assign ready      = ready_q;
  assign dl_error   = dl_error_q;
  assign byte_count = byte_count_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
module tb_rom_dl_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;
  localparam int FULL = 20512;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        prog_we, gfx_we, prom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        core_reset, ready, dl_error;
  logic [15:0] byte_count;
  logic [1:0]  dbg_state;

  // {region code[1:0], offset[15:0], data[7:0]}
  logic [25:0] exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cnt_prog = 0, cnt_gfx = 0, cnt_prom = 0, cnt_we = 0;
  int run_len = 0, last_run = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  rom_dl_sequencer dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .prog_we        (prog_we),
    .gfx_we         (gfx_we),
    .prom_we        (prom_we),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .core_reset     (core_reset),
    .ready          (ready),
    .dl_error       (dl_error),
    .byte_count     (byte_count),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference region map: prog 0x0000-0x3FFF, gfx 0x4000-0x4FFF, prom 0x5000-0x501F.
  function automatic logic model_decode(input logic [24:0] a, output logic [1:0] code,
                                        output logic [15:0] off);
    code = 2'd0;
    off  = 16'd0;
    if (a < 25'h4000) begin
      code = 2'd1; off = a[15:0];
    end else if (a < 25'h5000) begin
      code = 2'd2; off = 16'(a - 25'h4000);
    end else if (a < 25'h5020) begin
      code = 2'd3; off = 16'(a - 25'h5000);
    end
    return code != 2'd0;
  endfunction

  task automatic push_if_valid(input logic [24:0] a, input logic [7:0] d);
    logic [1:0]  code;
    logic [15:0] off;
    if (ioctl_download && model_decode(a, code, off)) exp_q.push_back({code, off, d});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_write(input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    push_if_valid(a, d);
  endtask

  task automatic drive_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
    end
  endtask

  task automatic set_download(input logic v);
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = v;
  endtask

  task automatic full_image(input int nbytes);
    set_download(1'b1);
    for (int i = 0; i < nbytes; i++) drive_write(25'(i), 8'(i ^ (i >> 8) ^ 8'h5A));
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor_loop();
    logic [25:0] e;
    logic [1:0]  code;
    forever begin
      @(negedge clk_sys);
      if (prog_we || gfx_we || prom_we) begin
        code = prog_we ? 2'd1 : (gfx_we ? 2'd2 : 2'd3);
        check("we_onehot", 32'($countones({prog_we, gfx_we, prom_we})), 32'd1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL we_unexpected: got region %0d addr 0x%0h data 0x%0h, expected no write",
                   code, rom_addr, rom_data);
        end else begin
          e = exp_q.pop_front();
          check("we_region", 32'(code), 32'(e[25:24]));
          check("we_addr", 32'(rom_addr), 32'(e[23:8]));
          check("we_data", 32'(rom_data), 32'(e[7:0]));
        end
        cnt_we++;
        if (prog_we) cnt_prog++;
        if (gfx_we)  cnt_gfx++;
        if (prom_we) cnt_prom++;
        run_len++;
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n, we_before, p0, g0, r0;
    logic saw_ready;
    fork
      monitor_loop();
    join_none

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_dl_error", 32'(dl_error), 32'd0);
    check("rst_byte_count", 32'(byte_count), 32'd0);
    check("rst_we", 32'({prog_we, gfx_we, prom_we}), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_rom_data", 32'(rom_data), 32'd0);
    reset = 1'b0;

    // Stray strobe with download low, then 8 back-to-back strobes with the
    // first one in the rising-edge cycle, then another stray strobe.
    we_before = cnt_we;
    drive_write(25'h0001, 8'hAA);
    drive_idle(3);
    check("stray_no_we", 32'(cnt_we), 32'(we_before));
    check("stray_no_count", 32'(byte_count), 32'd0);
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b1;
    ioctl_addr     = 25'h4000;
    ioctl_dout     = 8'h11;
    push_if_valid(25'h4000, 8'h11);
    drive_write(25'h0000, 8'h22);
    drive_write(25'h0FFF, 8'h33);
    drive_write(25'h3FFF, 8'h44);
    drive_write(25'h4FFF, 8'h55);
    drive_write(25'h5000, 8'h66);
    drive_write(25'h501F, 8'h77);
    drive_write(25'h1234, 8'h88);
    set_download(1'b0);
    drive_write(25'h0002, 8'h99);
    drive_idle(4);
    check("b2b_run_len", 32'(last_run), 32'd8);
    check("b2b_byte_count", 32'(byte_count), 32'd8);
    check("b2b_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("b2b_dl_error", 32'(dl_error), 32'd0);

    // Gap and out-of-window addresses
    set_download(1'b1);
    drive_write(25'h0010, 8'hC3);
    drive_write(25'h5020, 8'h01);
    drive_write(25'h6000, 8'h02);
    drive_write(25'h10000, 8'h03);
    drive_idle(2);
    check("gap_dl_error", 32'(dl_error), 32'd1);
    check("gap_byte_count", 32'(byte_count), 32'd1);
    check("gap_state_load", 32'(dbg_state), 32'(S_LOAD));
    set_download(1'b0);
    drive_idle(3);
    check("gap_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("gap_core_reset", 32'(core_reset), 32'd1);
    check("gap_error_sticky", 32'(dl_error), 32'd1);

    // Complete load and timed release
    p0 = cnt_prog; g0 = cnt_gfx; r0 = cnt_prom;
    full_image(FULL);
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    n = 0;
    while (core_reset && n < 100) begin
      @(negedge clk_sys);
      n++;
      if (n == 1) begin
        check("full_byte_count", 32'(byte_count), 32'(FULL));
        check("full_dl_error", 32'(dl_error), 32'd0);
        check("full_state_hold", 32'(dbg_state), 32'(S_HOLD));
      end
    end
    check("release_cycles", 32'(n), 32'd17);
    check("full_ready", 32'(ready), 32'd1);
    check("full_state_run", 32'(dbg_state), 32'(S_RUN));
    check("full_prog_we", 32'(cnt_prog - p0), 32'd16384);
    check("full_gfx_we", 32'(cnt_gfx - g0), 32'd4096);
    check("full_prom_we", 32'(cnt_prom - r0), 32'd32);

    // Restart during HOLD
    full_image(FULL);
    @(negedge clk_sys);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    saw_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_sys);
      if (ready) saw_ready = 1'b1;
      if (k == 1) check("restart_in_hold", 32'(dbg_state), 32'(S_HOLD));
    end
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    if (ready) saw_ready = 1'b1;
    check("restart_state_load", 32'(dbg_state), 32'(S_LOAD));
    check("restart_byte_count", 32'(byte_count), 32'd0);
    check("restart_core_reset", 32'(core_reset), 32'd1);
    check("restart_no_run", 32'(saw_ready), 32'd0);
    set_download(1'b0);
    drive_idle(2);
    check("restart_end_idle", 32'(dbg_state), 32'(S_IDLE));

    // Short image
    full_image(FULL - 1);
    set_download(1'b0);
    drive_idle(20);
    check("short_state_idle", 32'(dbg_state), 32'(S_IDLE));
    check("short_ready", 32'(ready), 32'd0);
    check("short_dl_error", 32'(dl_error), 32'd0);
    check("short_core_reset", 32'(core_reset), 32'd1);
    check("short_byte_count", 32'(byte_count), 32'(FULL - 1));

    // Reset mid-LOAD
    full_image(100);
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    reset    = 1'b1;
    @(negedge clk_sys);
    check("mrst_state", 32'(dbg_state), 32'(S_IDLE));
    check("mrst_we", 32'({prog_we, gfx_we, prom_we}), 32'd0);
    check("mrst_rom_addr", 32'(rom_addr), 32'd0);
    check("mrst_rom_data", 32'(rom_data), 32'd0);
    check("mrst_core_reset", 32'(core_reset), 32'd1);
    check("mrst_ready", 32'(ready), 32'd0);
    check("mrst_dl_error", 32'(dl_error), 32'd0);
    check("mrst_byte_count", 32'(byte_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) drive_write(25'(16'h4100 + i), 8'(8'hE0 + i));
    drive_idle(3);
    check("mrst_no_load", 32'(dbg_state), 32'(S_IDLE));
    check("mrst_post_count", 32'(byte_count), 32'd8);
    set_download(1'b0);
    drive_idle(2);
    check("mrst_still_idle", 32'(dbg_state), 32'(S_IDLE));
    set_download(1'b1);
    @(negedge clk_sys);
    check("mrst_rerise_load", 32'(dbg_state), 32'(S_LOAD));
    set_download(1'b0);
    drive_idle(4);
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
